// File: rtl/sb_pkg.sv
// Shared constants and types for the writeback scoreboard.
package sb_pkg;

    localparam int NREG    = 32;
    localparam int SCL_LAT = 3;
    localparam int VEC_LAT = 10;
    localparam int SLOT_W  = VEC_LAT + 1;
    localparam int SLOT_IW = $clog2(SLOT_W);

    typedef enum logic {
        PIPE_SCALAR = 1'b0,
        PIPE_VECTOR = 1'b1
    } pipe_e;

    typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/wb_slot_ring.sv
// Writeback slot reservation ring for one register-file write port.
// Bit k set means that port is claimed k cycles from now; bit 0 is this cycle.
module wb_slot_ring #(
    parameter int W  = 11,
    parameter int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rsv_en,
    input  logic [IW-1:0] rsv_idx,
    input  logic [IW-1:0] qry_idx,
    output logic          conflict,
    output logic          head,
    output logic [W-1:0]  slots
);

    logic [W-1:0] rsv_mask;

    // Reservation lands at rsv_idx after this edge's shift has been applied.
    always_comb begin
        rsv_mask = '0;
        if (rsv_en) rsv_mask[rsv_idx] = 1'b1;
    end

    // Advance one slot per cycle toward the head and merge the new claim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slots <= '0;
        else        slots <= {1'b0, slots[W-1:1]} | rsv_mask;
    end

    // A bit at qry_idx now would occupy qry_idx-1 next cycle, the slot a new claim wants.
    assign conflict = slots[qry_idx];
    assign head     = slots[0];

endmodule

// File: rtl/wb_scoreboard.sv
// Issue-side hazard controller: RAW/WAW stall on pending destinations and
// write-port slot booking between the short scalar and long vector pipelines.
module wb_scoreboard
    import sb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic            issue_pipe,
    input  logic            src_s1_en,
    input  logic            src_s2_en,
    input  reg_idx_t        src_s1,
    input  reg_idx_t        src_s2,
    input  logic            src_v1_en,
    input  logic            src_v2_en,
    input  reg_idx_t        src_v1,
    input  reg_idx_t        src_v2,
    input  logic            dst_s_en,
    input  reg_idx_t        dst_s,
    input  logic            dst_v_en,
    input  reg_idx_t        dst_v,
    input  logic            sret_en,
    input  reg_idx_t        sret_reg,
    input  logic            vret_en,
    input  reg_idx_t        vret_reg,
    output logic [NREG-1:0] pend_s,
    output logic [NREG-1:0] pend_v,
    output logic            busy,
    output logic            err
);

    localparam logic [SLOT_IW-1:0] L_SCL = SLOT_IW'(SCL_LAT);
    localparam logic [SLOT_IW-1:0] L_VEC = SLOT_IW'(VEC_LAT);

    logic [SLOT_IW-1:0] lat;
    logic               dst_s_live;
    logic               raw_hz, waw_hz, port_hz;
    logic               fire;
    logic               s_conf, v_conf, s_head, v_head;
    logic [SLOT_W-1:0]  s_slot, v_slot;
    logic [NREG-1:0]    set_s, clr_s, set_v, clr_v;
    logic               err_evt;

    // s0 is hardwired: writes to it are not tracked at all.
    assign dst_s_live = dst_s_en && (dst_s != '0);
    assign lat        = (pipe_e'(issue_pipe) == PIPE_VECTOR) ? L_VEC : L_SCL;

    // pend_s[0] can never be set, so reads of s0 never stall.
    assign raw_hz  = (src_s1_en && pend_s[src_s1]) || (src_s2_en && pend_s[src_s2]) ||
                     (src_v1_en && pend_v[src_v1]) || (src_v2_en && pend_v[src_v2]);
    assign waw_hz  = (dst_s_live && pend_s[dst_s]) || (dst_v_en && pend_v[dst_v]);
    assign port_hz = (dst_s_live && s_conf) || (dst_v_en && v_conf);

    // Same-cycle retires are not bypassed; the stall releases one cycle later.
    assign issue_ready = !(raw_hz || waw_hz || port_hz);
    assign fire        = issue_valid && issue_ready;

    wb_slot_ring #(.W(SLOT_W)) u_s_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (fire && dst_s_live),
        .rsv_idx  (lat - 1'b1),
        .qry_idx  (lat),
        .conflict (s_conf),
        .head     (s_head),
        .slots    (s_slot)
    );

    wb_slot_ring #(.W(SLOT_W)) u_v_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (fire && dst_v_en),
        .rsv_idx  (lat - 1'b1),
        .qry_idx  (lat),
        .conflict (v_conf),
        .head     (v_head),
        .slots    (v_slot)
    );

    // Decode per-register set (issue) and clear (retire) masks.
    always_comb begin
        set_s = '0;
        set_v = '0;
        clr_s = '0;
        clr_v = '0;
        if (fire && dst_s_live) set_s[dst_s]    = 1'b1;
        if (fire && dst_v_en)   set_v[dst_v]    = 1'b1;
        if (sret_en)            clr_s[sret_reg] = 1'b1;
        if (vret_en)            clr_v[vret_reg] = 1'b1;
    end

    // Pending bitmaps; WAW stall keeps set and clear of the same bit apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_s <= '0;
            pend_v <= '0;
        end else begin
            pend_s <= (pend_s & ~clr_s) | set_s;
            pend_v <= (pend_v & ~clr_v) | set_v;
        end
    end

    // Retire strobes must line up with booked slots and with pending registers.
    assign err_evt = (sret_en != s_head) || (vret_en != v_head) ||
                     (sret_en && !pend_s[sret_reg]) ||
                     (vret_en && !pend_v[vret_reg]) ||
                     (sret_en && (sret_reg == '0));

    // Sticky protocol error; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err <= 1'b0;
        else if (err_evt) err <= 1'b1;
    end

    assign busy = (|pend_s) || (|pend_v) || (|s_slot) || (|v_slot);

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench: the bench plays writeback from a calendar of booked
// retire cycles and checks the DUT against a cycle-indexed reference model.
module tb_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready, issue_pipe;
    logic        src_s1_en, src_s2_en, src_v1_en, src_v2_en;
    logic [4:0]  src_s1, src_s2, src_v1, src_v2;
    logic        dst_s_en, dst_v_en;
    logic [4:0]  dst_s, dst_v;
    logic        sret_en, vret_en;
    logic [4:0]  sret_reg, vret_reg;
    logic [31:0] pend_s, pend_v;
    logic        busy, err;

    always #5 clk = ~clk;

    wb_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pipe(issue_pipe),
        .src_s1_en(src_s1_en), .src_s2_en(src_s2_en), .src_s1(src_s1), .src_s2(src_s2),
        .src_v1_en(src_v1_en), .src_v2_en(src_v2_en), .src_v1(src_v1), .src_v2(src_v2),
        .dst_s_en(dst_s_en), .dst_s(dst_s), .dst_v_en(dst_v_en), .dst_v(dst_v),
        .sret_en(sret_en), .sret_reg(sret_reg), .vret_en(vret_en), .vret_reg(vret_reg),
        .pend_s(pend_s), .pend_v(pend_v), .busy(busy), .err(err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending sets plus a calendar cycle -> register of booked writebacks.
    logic [31:0] m_ps, m_pv;
    bit          m_err;
    int          s_wb[int];
    int          v_wb[int];
    int          cyc;
    bit          inj_s;
    logic [4:0]  inj_reg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic pipe);
        return pipe ? 10 : 3;
    endfunction

    function automatic bit model_ready();
        int  l;
        bit  dse;
        l   = lat_of(issue_pipe);
        dse = dst_s_en && (dst_s != 0);
        if (src_s1_en && src_s1 != 0 && m_ps[src_s1]) return 1'b0;
        if (src_s2_en && src_s2 != 0 && m_ps[src_s2]) return 1'b0;
        if (src_v1_en && m_pv[src_v1]) return 1'b0;
        if (src_v2_en && m_pv[src_v2]) return 1'b0;
        if (dse && m_ps[dst_s]) return 1'b0;
        if (dst_v_en && m_pv[dst_v]) return 1'b0;
        if (dse && s_wb.exists(cyc + l)) return 1'b0;
        if (dst_v_en && v_wb.exists(cyc + l)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_ins(input bit v, input bit pipe,
                           input bit s1e, input logic [4:0] s1, input bit s2e, input logic [4:0] s2,
                           input bit v1e, input logic [4:0] v1, input bit v2e, input logic [4:0] v2,
                           input bit dse, input logic [4:0] ds, input bit dve, input logic [4:0] dv);
        issue_valid = v;   issue_pipe = pipe;
        src_s1_en = s1e;   src_s1 = s1;   src_s2_en = s2e; src_s2 = s2;
        src_v1_en = v1e;   src_v1 = v1;   src_v2_en = v2e; src_v2 = v2;
        dst_s_en  = dse;   dst_s  = ds;   dst_v_en  = dve; dst_v  = dv;
    endtask

    task automatic idle();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: drive booked retires, check ready, advance model, check registered state.
    task automatic cycle(output bit rdy);
        bit exp_rdy, fire, s_bk, v_bk;
        int l;
        s_bk     = s_wb.exists(cyc) != 0;
        v_bk     = v_wb.exists(cyc) != 0;
        sret_en  = inj_s || s_bk;
        sret_reg = inj_s ? inj_reg : (s_bk ? 5'(s_wb[cyc]) : 5'd0);
        vret_en  = v_bk;
        vret_reg = v_bk ? 5'(v_wb[cyc]) : 5'd0;
        #1;
        exp_rdy = model_ready();
        chk("issue_ready", issue_ready, exp_rdy);
        rdy  = issue_ready;
        fire = issue_valid && exp_rdy;
        if (sret_en) begin
            if (sret_reg == 0 || !m_ps[sret_reg]) m_err = 1'b1;
            m_ps[sret_reg] = 1'b0;
        end
        if (vret_en) begin
            if (!m_pv[vret_reg]) m_err = 1'b1;
            m_pv[vret_reg] = 1'b0;
        end
        if (sret_en != s_bk || vret_en != v_bk) m_err = 1'b1;
        if (fire) begin
            l = lat_of(issue_pipe);
            if (dst_s_en && dst_s != 0) begin m_ps[dst_s] = 1'b1; s_wb[cyc + l] = dst_s; end
            if (dst_v_en)               begin m_pv[dst_v] = 1'b1; v_wb[cyc + l] = dst_v; end
        end
        s_wb.delete(cyc);
        v_wb.delete(cyc);
        @(posedge clk);
        #1;
        cyc++;
        chk("pend_s", pend_s, m_ps);
        chk("pend_v", pend_v, m_pv);
        chk("busy", busy, (m_ps != 0) || (m_pv != 0) || s_wb.num() != 0 || v_wb.num() != 0);
        chk("err", err, m_err);
    endtask

    task automatic drain();
        bit r;
        int k = 0;
        idle();
        while ((m_ps != 0 || m_pv != 0 || s_wb.num() != 0 || v_wb.num() != 0) && k < 30) begin
            cycle(r);
            k++;
        end
        chk("drain_bound", k < 30, 1);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        idle();
        sret_en = 0; vret_en = 0; inj_s = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_err",    err,    0);
        chk("rst_pend_s", pend_s, 0);
        chk("rst_pend_v", pend_v, 0);
        chk("rst_busy",   busy,   0);
        m_ps = '0; m_pv = '0; m_err = 0;
        s_wb.delete();
        v_wb.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_ready", issue_ready, 1);
    endtask

    initial begin
        bit r;
        int n;
        rst_n = 1'b0;
        idle();
        sret_en = 0; sret_reg = 0; vret_en = 0; vret_reg = 0;
        inj_s = 0; inj_reg = 0;
        m_ps = '0; m_pv = '0; m_err = 0; cyc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_pend_s", pend_s, 0);
        chk("reset_pend_v", pend_v, 0);
        chk("reset_busy",   busy,   0);
        chk("reset_err",    err,    0);
        chk("reset_ready",  issue_ready, 1);

        // Scalar RAW: writer of s5 then reader of s5 stalls 3 cycles.
        set_ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        cycle(r);
        chk("raw_fire0", r, 1);
        set_ins(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
        cycle(r);
        while (!r && n < 20) begin n++; cycle(r); end
        chk("raw_stall", n, 3);
        chk("raw_pend5", pend_s[5], 0);
        drain();

        // Port collision: vector op writing s7, scalar op writing s8 seven cycles later.
        set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        cycle(r);
        chk("coll_t0", r, 1);
        idle();
        repeat (6) cycle(r);
        set_ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0);
        cycle(r);
        chk("coll_t7", r, 0);
        cycle(r);
        chk("coll_t8", r, 1);
        drain();

        // Vector WAW on v3: second writer waits for the first retire.
        set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        cycle(r);
        n = 0;
        cycle(r);
        while (!r && n < 20) begin n++; cycle(r); end
        chk("waw_stall", n, 10);
        idle();
        cycle(r);
        chk("waw_pv3", pend_v[3], 1);
        drain();

        // s0 writes are dropped and s0 reads never stall.
        set_ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(r);
        chk("r0_ready", r, 1);
        chk("r0_pend", pend_s, 0);
        chk("r0_busy", busy, 0);
        set_ins(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(r);
        chk("r0_read", r, 1);

        // Stray retire sets sticky err; reset clears it together with tracking.
        idle();
        inj_s = 1; inj_reg = 9;
        cycle(r);
        inj_s = 0;
        chk("inj_err", err, 1);
        repeat (3) cycle(r);
        chk("inj_sticky", err, 1);
        set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2);
        cycle(r);
        do_reset();
        chk("post_rst_err", err, 0);

        // Dual destination books both ports ten cycles out.
        set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 6);
        cycle(r);
        chk("dual_fire", r, 1);
        idle();
        repeat (9) cycle(r);
        chk("dual_busy_pre", busy, 1);
        cycle(r);
        chk("dual_busy_post", busy, 0);

        // Random traffic over a small register window to provoke hazards.
        repeat (400) begin
            set_ins($urandom_range(0, 9) < 7, $urandom_range(0, 1),
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)));
            cycle(r);
        end
        drain();
        chk("final_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
